// File: rtl/icache_bank_array_if.sv
// Fetch-side bundle for the N-bank instruction-cache model: per-bank request/response handshakes,
// a common flush and the per-bank statistics outputs.
interface icache_bank_array_if #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned LINE_W    = 128
);
    logic                          flush;
    logic [NUM_BANKS-1:0]          req_v;
    logic [NUM_BANKS*ADDR_W-1:0]   req_addr;
    logic [NUM_BANKS-1:0]          req_rdy;
    logic [NUM_BANKS-1:0]          rsp_v;
    logic [NUM_BANKS-1:0]          rsp_rdy;
    logic [NUM_BANKS*LINE_W-1:0]   rsp_line;
    logic [NUM_BANKS-1:0]          rsp_miss;
    logic [NUM_BANKS*16-1:0]       stat_hits;
    logic [NUM_BANKS*16-1:0]       stat_miss;

    modport master (
        output flush, req_v, req_addr, rsp_rdy,
        input  req_rdy, rsp_v, rsp_line, rsp_miss, stat_hits, stat_miss
    );

    modport slave (
        input  flush, req_v, req_addr, rsp_rdy,
        output req_rdy, rsp_v, rsp_line, rsp_miss, stat_hits, stat_miss
    );
endinterface

// File: rtl/icache_bank_array.sv
// N-bank instruction-cache model with periodic deterministic misses and synthetic address-tagged lines.
// Optional per-bank hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_bank_array #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned MISS_FREQ = 2,
    parameter int unsigned MISS_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    icache_bank_array_if.slave   bus
);

    localparam int unsigned ACC_W = $clog2(MISS_FREQ + 1) + 1;
    localparam int unsigned LAT_W = $clog2(MISS_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_RESP = 2'd2
    } state_e;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        state_e             state_q, state_d;
        logic [ACC_W-1:0]   acc_q,   acc_d;
        logic [LAT_W-1:0]   lat_q,   lat_d;
        logic               rdy_q,   rdy_d;
        logic               vld_q,   vld_d;
        logic               miss_q,  miss_d;
        logic [LINE_W-1:0]  line_q,  line_d;
        logic [ADDR_W-1:0]  addr_c;

        assign addr_c = bus.req_addr[b*ADDR_W +: ADDR_W];

        // Next-state: flush is applied last so it overrides accept and consume.
        always_comb begin
            state_d = state_q;
            acc_d   = acc_q;
            lat_d   = lat_q;
            miss_d  = miss_q;
            line_d  = line_q;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_v[b]) begin
                        line_d                      = '0;
                        line_d[LINE_W-1 -: ADDR_W]  = addr_c;
                        line_d[31:16]               = {8'hBA, 8'(b)};
                        line_d[15:0]                = 16'hFEED;
                        if (acc_q == ACC_W'(MISS_FREQ)) begin
                            acc_d = '0;
                            if (MISS_LAT == 0) begin
                                state_d = S_RESP;
                                miss_d  = 1'b1;
                            end else begin
                                lat_d   = LAT_W'(MISS_LAT);
                                state_d = S_MISS;
                            end
                        end else begin
                            acc_d   = acc_q + ACC_W'(1);
                            state_d = S_RESP;
                            miss_d  = 1'b0;
                        end
                    end
                end
                S_MISS: begin
                    lat_d = lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        state_d = S_RESP;
                        miss_d  = 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_rdy[b]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (bus.flush) begin
                state_d = S_IDLE;
                acc_d   = '0;
                lat_d   = '0;
                line_d  = line_q;
            end
            rdy_d = (state_d == S_IDLE);
            vld_d = (state_d == S_RESP);
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                lat_q   <= '0;
                rdy_q   <= 1'b1;
                vld_q   <= 1'b0;
                miss_q  <= 1'b0;
                line_q  <= '0;
            end else begin
                state_q <= state_d;
                acc_q   <= acc_d;
                lat_q   <= lat_d;
                rdy_q   <= rdy_d;
                vld_q   <= vld_d;
                miss_q  <= miss_d;
                line_q  <= line_d;
            end
        end

        assign bus.req_rdy[b]                    = rdy_q;
        assign bus.rsp_v[b]                      = vld_q;
        assign bus.rsp_miss[b]                   = miss_q;
        assign bus.rsp_line[b*LINE_W +: LINE_W]  = line_q;

`ifdef ICACHE_STATS_EN
        logic        enter_resp_c;
        logic [15:0] hits_q;
        logic [15:0] misses_q;

        assign enter_resp_c = (state_q != S_RESP) && (state_d == S_RESP);

        // Saturating counters, one bump per RESP entry.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                hits_q   <= '0;
                misses_q <= '0;
            end else if (enter_resp_c) begin
                if (miss_d && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
                if (!miss_d && hits_q != 16'hFFFF)  hits_q   <= hits_q + 16'd1;
            end
        end

        assign bus.stat_hits[b*16 +: 16] = hits_q;
        assign bus.stat_miss[b*16 +: 16] = misses_q;
`else
        assign bus.stat_hits[b*16 +: 16] = 16'd0;
        assign bus.stat_miss[b*16 +: 16] = 16'd0;
`endif
    end

endmodule

// File: tb/tb_icache_bank_array.sv
// Directed bench for icache_bank_array: default-config instance plus a MISS_FREQ=0/MISS_LAT=0 instance.
module tb_icache_bank_array;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic clr;
    int   n_chk;
    int   n_pass;
    int   n_fail;
    logic [127:0] exp_line;

    icache_bank_array_if #(.NUM_BANKS(2), .ADDR_W(27), .LINE_W(128)) bus0 ();
    icache_bank_array_if #(.NUM_BANKS(2), .ADDR_W(27), .LINE_W(128)) bus1 ();

    icache_bank_array #(
        .NUM_BANKS(2), .ADDR_W(27), .LINE_W(128), .MISS_FREQ(2), .MISS_LAT(4)
    ) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0.slave)
    );

    icache_bank_array #(
        .NUM_BANKS(2), .ADDR_W(27), .LINE_W(128), .MISS_FREQ(0), .MISS_LAT(0)
    ) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        clr    = 1'b1;
        bus0.flush = 1'b0; bus0.req_v = '0; bus0.req_addr = '0; bus0.rsp_rdy = '0;
        bus1.flush = 1'b0; bus1.req_v = '0; bus1.req_addr = '0; bus1.rsp_rdy = '0;
        step();
        step();

        // Reset state
        chk("rst_rsp_v",  256'(bus0.rsp_v),     256'(2'b00));
        chk("rst_line",   256'(bus0.rsp_line),  256'(0));
        chk("rst_miss",   256'(bus0.rsp_miss),  256'(2'b00));
        chk("rst_hits",   256'(bus0.stat_hits), 256'(0));
        clr = 1'b0;
        step();
        chk("rst_rdy",    256'(bus0.req_rdy),   256'(2'b11));

        // T2: bank0 hit, hit, miss
        bus0.req_addr[26:0] = 27'h0000123;
        bus0.rsp_rdy = 2'b11;
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t2_hit1_v",    256'(bus0.rsp_v[0]),    256'(1));
        chk("t2_hit1_miss", 256'(bus0.rsp_miss[0]), 256'(0));
        chk("t2_hit1_rdy",  256'(bus0.req_rdy[0]),  256'(0));
        step();
        chk("t2_idle_rdy",  256'(bus0.req_rdy[0]),  256'(1));
        chk("t2_idle_v",    256'(bus0.rsp_v[0]),    256'(0));
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t2_hit2_v",    256'(bus0.rsp_v[0]),    256'(1));
        chk("t2_hit2_miss", 256'(bus0.rsp_miss[0]), 256'(0));
        step();
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t2_miss_w1_v",   256'(bus0.rsp_v[0]),   256'(0));
        chk("t2_miss_w1_rdy", 256'(bus0.req_rdy[0]), 256'(0));
        step(); step(); step();
        chk("t2_miss_w4_v",   256'(bus0.rsp_v[0]),   256'(0));
        step();
        chk("t2_miss_v",    256'(bus0.rsp_v[0]),        256'(1));
        chk("t2_miss_flag", 256'(bus0.rsp_miss[0]),     256'(1));
        chk("t2_line_addr", 256'(bus0.rsp_line[127:101]), 256'(27'h0000123));
        chk("t2_line_low",  256'(bus0.rsp_line[31:0]),  256'(32'hBA00FEED));
        step();

        // T4: backpressure on bank0 (hit after the miss reset the access count)
        bus0.rsp_rdy[0] = 1'b0;
        bus0.req_addr[26:0] = 27'h5A5A5A5;
        exp_line = {27'h5A5A5A5, 69'd0, 32'hBA00FEED};
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t4_hold_v",    256'(bus0.rsp_v[0]),         256'(1));
            chk("t4_hold_line", 256'(bus0.rsp_line[127:0]),  256'(exp_line));
            chk("t4_hold_rdy",  256'(bus0.req_rdy[0]),       256'(0));
            step();
        end
        bus0.rsp_rdy[0] = 1'b1;
        chk("t4_last_miss", 256'(bus0.rsp_miss[0]), 256'(0));
        step();
        chk("t4_rel_v",   256'(bus0.rsp_v[0]),   256'(0));
        chk("t4_rel_rdy", 256'(bus0.req_rdy[0]), 256'(1));

        // T3: bank1 miss in flight while bank0 hits
        bus0.req_addr[53:27] = 27'h7654321;
        for (int i = 0; i < 2; i++) begin
            bus0.req_v[1] = 1'b1; step(); bus0.req_v[1] = 1'b0;
            chk("t3_b1_hit_v",    256'(bus0.rsp_v[1]),    256'(1));
            chk("t3_b1_hit_miss", 256'(bus0.rsp_miss[1]), 256'(0));
            step();
        end
        bus0.req_v[1] = 1'b1; step(); bus0.req_v[1] = 1'b0;
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t3_b0_hit_v",    256'(bus0.rsp_v[0]),    256'(1));
        chk("t3_b0_hit_miss", 256'(bus0.rsp_miss[0]), 256'(0));
        chk("t3_b1_wait_a",   256'(bus0.rsp_v[1]),    256'(0));
        step(); step();
        chk("t3_b1_wait_b",   256'(bus0.rsp_v[1]),    256'(0));
        step();
        chk("t3_b1_v",        256'(bus0.rsp_v[1]),             256'(1));
        chk("t3_b1_miss",     256'(bus0.rsp_miss[1]),          256'(1));
        chk("t3_b1_low",      256'(bus0.rsp_line[159:128]),    256'(32'hBA01FEED));
        chk("t3_b1_addr",     256'(bus0.rsp_line[255:229]),    256'(27'h7654321));
        step();

        // T5: flush during bank0 miss with a same-cycle request
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t5_miss_wait", 256'(bus0.rsp_v[0]), 256'(0));
        step();
        bus0.flush = 1'b1; bus0.req_v[0] = 1'b1;
        step();
        bus0.flush = 1'b0; bus0.req_v[0] = 1'b0;
        chk("t5_flush_v",   256'(bus0.rsp_v[0]),   256'(0));
        chk("t5_flush_rdy", 256'(bus0.req_rdy[0]), 256'(1));
        repeat (5) step();
        chk("t5_no_rsp",    256'(bus0.rsp_v[0]),   256'(0));
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        chk("t5_next_v",    256'(bus0.rsp_v[0]),    256'(1));
        chk("t5_next_miss", 256'(bus0.rsp_miss[0]), 256'(0));
        step();

        // T1: clr pulse in the middle of a bank0 miss
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        step();
        bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
        step();
        chk("stat_hits", 256'(bus0.stat_hits), STATS ? 256'({16'd2, 16'd6}) : 256'(0));
        chk("stat_miss", 256'(bus0.stat_miss), STATS ? 256'({16'd1, 16'd1}) : 256'(0));
        clr = 1'b1;
        #1;
        chk("t1_clr_v",    256'(bus0.rsp_v),     256'(2'b00));
        chk("t1_clr_hits", 256'(bus0.stat_hits), 256'(0));
        step();
        clr = 1'b0;
        step();
        chk("t1_rel_rdy",  256'(bus0.req_rdy),   256'(2'b11));
        chk("t1_rel_v",    256'(bus0.rsp_v),     256'(2'b00));
        for (int i = 0; i < 2; i++) begin
            bus0.req_v[0] = 1'b1; step(); bus0.req_v[0] = 1'b0;
            chk("t1_hit_v",    256'(bus0.rsp_v[0]),    256'(1));
            chk("t1_hit_miss", 256'(bus0.rsp_miss[0]), 256'(0));
            step();
        end

        // T6: every access misses with zero extra latency
        bus1.rsp_rdy[0] = 1'b1;
        bus1.req_addr[26:0] = 27'h4000001;
        for (int i = 0; i < 4; i++) begin
            bus1.req_v[0] = 1'b1; step(); bus1.req_v[0] = 1'b0;
            chk("t6_v",    256'(bus1.rsp_v[0]),    256'(1));
            chk("t6_miss", 256'(bus1.rsp_miss[0]), 256'(1));
            step();
        end
        chk("t6_stat_miss", 256'(bus1.stat_miss[15:0]), STATS ? 256'(16'd4) : 256'(0));
        chk("t6_stat_hits", 256'(bus1.stat_hits[15:0]), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
